// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default width and FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DZ   = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Execute-stage request/result bundle for the iterative divider.
interface div_iter_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             cancel;
  logic             signed_op;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start, cancel, signed_op, dividend_i, divisor_i,
    input  quotient_o, remainder_o, busy_o, done_o
  );

  modport slave (
    input  start, cancel, signed_op, dividend_i, divisor_i,
    output quotient_o, remainder_o, busy_o, done_o
  );

endinterface

// File: rtl/div_clz.sv
// Combinational leading-zero count; an all-zero input reports WIDTH.
module div_clz
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [CNT_W-1:0] count_o
);

  // Ascending scan: the last set bit visited is the most significant one.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with signed/unsigned modes, divide-by-zero and cancel.
// Optional early termination on short dividends: define DIV_EARLY_TERM_EN.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] partRem_q, partRem_d;
  logic [WIDTH-1:0] quoShift_q, quoShift_d;
  logic [WIDTH-1:0] divMag_q, divMag_d;
  logic [WIDTH-1:0] quotRes_q, quotRes_d;
  logic [WIDTH-1:0] remRes_q, remRes_d;
  logic             negQuot_q, negQuot_d;
  logic             negRem_q, negRem_d;

  logic             dvdNeg, dvsNeg, accept;
  logic [WIDTH-1:0] dvdMag, dvsMag, loadQuo;
  logic [CNT_W-1:0] loadCnt;
  logic [WIDTH:0]   shiftRem, diffRem;

  assign dvdNeg = bus.signed_op & bus.dividend_i[WIDTH-1];
  assign dvsNeg = bus.signed_op & bus.divisor_i[WIDTH-1];
  assign dvdMag = dvdNeg ? -bus.dividend_i : bus.dividend_i;
  assign dvsMag = dvsNeg ? -bus.divisor_i : bus.divisor_i;
  assign accept = bus.start & ~bus.cancel;

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] dvdClz;

  div_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) uClz (
    .value_i (dvdMag),
    .count_o (dvdClz)
  );

  // Leading zeros are skipped; a zero dividend still runs one step.
  assign loadCnt = (dvdClz == CNT_W'(WIDTH)) ? CNT_W'(1) : CNT_W'(WIDTH) - dvdClz;
  assign loadQuo = dvdMag << dvdClz;
`else
  assign loadCnt = CNT_W'(WIDTH);
  assign loadQuo = dvdMag;
`endif

  assign shiftRem = {partRem_q, quoShift_q[WIDTH-1]};
  assign diffRem  = shiftRem - {1'b0, divMag_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      partRem_q  <= '0;
      quoShift_q <= '0;
      divMag_q   <= '0;
      quotRes_q  <= '0;
      remRes_q   <= '0;
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      partRem_q  <= partRem_d;
      quoShift_q <= quoShift_d;
      divMag_q   <= divMag_d;
      quotRes_q  <= quotRes_d;
      remRes_q   <= remRes_d;
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    partRem_d  = partRem_q;
    quoShift_d = quoShift_q;
    divMag_d   = divMag_q;
    quotRes_d  = quotRes_q;
    remRes_d   = remRes_q;
    negQuot_d  = negQuot_q;
    negRem_d   = negRem_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          negQuot_d = dvdNeg ^ dvsNeg;
          negRem_d  = dvdNeg;
          divMag_d  = dvsMag;
          // DZ reuses the partial-remainder register to carry the raw dividend.
          if (bus.divisor_i == '0) begin
            partRem_d = bus.dividend_i;
            state_d   = DZ;
          end else begin
            partRem_d  = '0;
            quoShift_d = loadQuo;
            cnt_d      = loadCnt;
            state_d    = CALC;
          end
        end
      end
      DZ: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          quotRes_d = '1;
          remRes_d  = partRem_q;
          state_d   = DONE;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!diffRem[WIDTH]) begin
            partRem_d  = diffRem[WIDTH-1:0];
            quoShift_d = {quoShift_q[WIDTH-2:0], 1'b1};
          end else begin
            partRem_d  = shiftRem[WIDTH-1:0];
            quoShift_d = {quoShift_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          quotRes_d = negQuot_q ? -quoShift_q : quoShift_q;
          remRes_d  = negRem_q ? -partRem_q : partRem_q;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.quotient_o  = quotRes_q;
  assign bus.remainder_o = remRes_q;
  assign bus.busy_o      = (state_q == DZ) || (state_q == CALC) || (state_q == FIX);
  assign bus.done_o      = (state_q == DONE);

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter at WIDTH=32; honours DIV_EARLY_TERM_EN in its latency model.
module tb_div_iter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int clzModel(input logic [W-1:0] v);
    int n = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i] && n == W) n = W - 1 - i;
    end
    return n;
  endfunction

  // Reference result via native division on magnitudes; lat counts edges from the start edge to done.
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic         an, bn;
    logic [W-1:0] am, bm;
    int           it;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.lat = 1;
      return e;
    end
    an  = sgn & a[W-1];
    bn  = sgn & b[W-1];
    am  = an ? -a : a;
    bm  = bn ? -b : b;
    e.q = am / bm;
    e.r = am % bm;
    if (an ^ bn) e.q = -e.q;
    if (an) e.r = -e.r;
`ifdef DIV_EARLY_TERM_EN
    it = W - clzModel(am);
    if (it < 1) it = 1;
`else
    it = W;
`endif
    e.lat = it + 1;
    return e;
  endfunction

  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit pokeStart);
    exp_t         e;
    logic [W-1:0] prevQ, prevR;
    int           cycles, busyCycles;
    sb.push_back(model(sgn, a, b));
    @(negedge clk);
    prevQ          = bus.quotient_o;
    prevR          = bus.remainder_o;
    bus.signed_op  = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.signed_op  = ~sgn;
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
    checkOutput("holdQ", bus.quotient_o, prevQ);
    checkOutput("holdR", bus.remainder_o, prevR);
    cycles     = 0;
    busyCycles = 0;
    while (!bus.done_o && cycles < 200) begin
      if (bus.busy_o) busyCycles++;
      if (pokeStart) bus.start = (cycles == 3);
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.start = 1'b0;
    checkOutput("doneSeen", {31'b0, bus.done_o}, 32'd1);
    e = sb.pop_front();
    checkOutput("quotient", bus.quotient_o, e.q);
    checkOutput("remainder", bus.remainder_o, e.r);
    checkOutput("latency", 32'(cycles), 32'(e.lat));
    checkOutput("busyCycles", 32'(busyCycles), 32'(e.lat));
    @(posedge clk);
    #1;
    checkOutput("donePulse", {31'b0, bus.done_o}, 32'd0);
  endtask

  task automatic applyCancel();
    logic [W-1:0] prevQ, prevR;
    int           dones;
    @(negedge clk);
    prevQ          = bus.quotient_o;
    prevR          = bus.remainder_o;
    bus.signed_op  = 1'b0;
    bus.dividend_i = 32'hFFFF_0000;
    bus.divisor_i  = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    checkOutput("cancelBusy", {31'b0, bus.busy_o}, 32'd0);
    dones = 0;
    repeat (40) begin
      if (bus.done_o) dones++;
      @(posedge clk);
      #1;
    end
    checkOutput("cancelNoDone", 32'(dones), 32'd0);
    checkOutput("cancelHoldQ", bus.quotient_o, prevQ);
    checkOutput("cancelHoldR", bus.remainder_o, prevR);
  endtask

  task automatic applyReset();
    @(negedge clk);
    bus.signed_op  = 1'b0;
    bus.dividend_i = 32'h7FFF_FFFF;
    bus.divisor_i  = 32'd7;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rstQ", bus.quotient_o, '0);
    checkOutput("rstR", bus.remainder_o, '0);
    checkOutput("rstBusy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("rstDone", {31'b0, bus.done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.cancel     = 1'b0;
    bus.signed_op  = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetQ", bus.quotient_o, '0);
    checkOutput("resetR", bus.remainder_o, '0);
    checkOutput("resetBusy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("resetDone", {31'b0, bus.done_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(1'b1, 32'h1234, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h1234, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 32'hFFFF), 1'b0);
    end

    applyCancel();
    applyStimulus(1'b0, 32'd20, 32'd3, 1'b0);

    // Start accompanied by cancel must not launch an operation.
    @(negedge clk);
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    bus.start      = 1'b1;
    bus.cancel     = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    checkOutput("startCancelBusy", {31'b0, bus.busy_o}, 32'd0);

    applyReset();
    applyStimulus(1'b0, 32'd9, 32'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
